// File: rtl/samcoupe_midi.sv
// samcoupe_midi: 31250-baud 8N1 MIDI engine for SAM Coupe port 253.
// Double-buffered TX with a timed out-interrupt, and RX with a holding register and error flags.
module samcoupe_midi #(
  parameter int BIT_TICKS = 32,
  parameter int INT_TICKS = 16
) (
  input  logic       clk_sys,
  input  logic       rst_n,
  input  logic       ce,
  input  logic       wr,
  input  logic       rd,
  input  logic [7:0] din,
  output logic [7:0] dout,
  input  logic       rxd,
  output logic       txd,
  output logic       tx_ready,
  output logic       int_tx,
  output logic       rx_full,
  output logic       frame_err,
  output logic       overrun
);
  localparam int CW = $clog2(BIT_TICKS);
  localparam int IW = $clog2(INT_TICKS);
  localparam logic [CW-1:0] BIT_END = CW'(BIT_TICKS - 1);
  localparam logic [CW-1:0] HALF_END = CW'(BIT_TICKS / 2 - 1);
  localparam logic [IW-1:0] INT_END = IW'(INT_TICKS - 1);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_GUARD} rx_state_t;

  tx_state_t tx_state, tx_state_n;
  logic [CW-1:0] tx_cnt, tx_cnt_n;
  logic [2:0] tx_bit, tx_bit_n;
  logic [7:0] tx_hold, tx_sh, tx_sh_n;
  logic tx_full, tx_load, tx_stop_end;
  logic [IW-1:0] int_cnt;

  rx_state_t rx_state, rx_state_n;
  logic [CW-1:0] rx_cnt, rx_cnt_n;
  logic [2:0] rx_bit, rx_bit_n;
  logic [7:0] rx_sh, rx_sh_n, rx_data;
  logic rx_s1, rx_s2, rx_last, rx_done;

  assign tx_ready = ~tx_full;
  assign dout = rx_data;
  assign txd = tx_state == TX_START ? 1'b0 : tx_state == TX_DATA ? tx_sh[0] : 1'b1;

  always_comb begin
    tx_state_n = tx_state;
    tx_cnt_n = tx_cnt;
    tx_bit_n = tx_bit;
    tx_sh_n = tx_sh;
    tx_load = 1'b0;
    tx_stop_end = 1'b0;
    if (ce) begin
      tx_cnt_n = tx_cnt == BIT_END ? '0 : tx_cnt + 1'b1;
      case (tx_state)
        TX_IDLE: begin
          tx_cnt_n = '0;
          tx_load = tx_full;
        end
        TX_START: if (tx_cnt == BIT_END) tx_state_n = TX_DATA;
        TX_DATA: if (tx_cnt == BIT_END) begin
          tx_sh_n = tx_sh >> 1;
          tx_bit_n = tx_bit + 1'b1;
          tx_state_n = tx_bit == 3'd7 ? TX_STOP : TX_DATA;
        end
        default: if (tx_cnt == BIT_END) begin
          tx_stop_end = 1'b1;
          tx_load = tx_full;
          tx_state_n = TX_IDLE;
        end
      endcase
      // a full holding register starts the next frame without an idle gap
      if (tx_load) begin
        tx_sh_n = tx_hold;
        tx_bit_n = 3'd0;
        tx_state_n = TX_START;
      end
    end
  end

  always_ff @(posedge clk_sys or negedge rst_n)
    if (!rst_n) begin
      tx_state <= TX_IDLE;
      tx_cnt <= '0;
      tx_bit <= '0;
      tx_sh <= '0;
      tx_hold <= '0;
      tx_full <= 1'b0;
      int_tx <= 1'b0;
      int_cnt <= '0;
    end else begin
      tx_state <= tx_state_n;
      tx_cnt <= tx_cnt_n;
      tx_bit <= tx_bit_n;
      tx_sh <= tx_sh_n;
      if (wr && !tx_full) begin
        tx_hold <= din;
        tx_full <= 1'b1;
      end else if (tx_load) tx_full <= 1'b0;
      if (tx_stop_end) begin
        int_tx <= 1'b1;
        int_cnt <= '0;
      end else if (ce && int_tx) begin
        int_cnt <= int_cnt == INT_END ? '0 : int_cnt + 1'b1;
        if (int_cnt == INT_END) int_tx <= 1'b0;
      end
    end

  always_comb begin
    rx_state_n = rx_state;
    rx_cnt_n = rx_cnt;
    rx_bit_n = rx_bit;
    rx_sh_n = rx_sh;
    rx_done = 1'b0;
    if (ce) begin
      rx_cnt_n = rx_cnt == BIT_END ? '0 : rx_cnt + 1'b1;
      case (rx_state)
        RX_IDLE: begin
          rx_cnt_n = '0;
          if (rx_last && !rx_s2) rx_state_n = RX_START;
        end
        RX_START: if (rx_cnt == HALF_END) begin
          rx_cnt_n = '0;
          rx_bit_n = 3'd0;
          rx_state_n = rx_s2 ? RX_IDLE : RX_DATA;
        end
        RX_DATA: if (rx_cnt == BIT_END) begin
          rx_sh_n = {rx_s2, rx_sh[7:1]};
          rx_bit_n = rx_bit + 1'b1;
          rx_state_n = rx_bit == 3'd7 ? RX_STOP : RX_DATA;
        end
        RX_STOP: if (rx_cnt == BIT_END) begin
          rx_done = 1'b1;
          rx_state_n = rx_s2 ? RX_IDLE : RX_GUARD;
        end
        default: begin
          rx_cnt_n = '0;
          if (rx_s2) rx_state_n = RX_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk_sys or negedge rst_n)
    if (!rst_n) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      rx_last <= 1'b0;
      rx_state <= RX_IDLE;
      rx_cnt <= '0;
      rx_bit <= '0;
      rx_sh <= '0;
      rx_data <= '0;
      rx_full <= 1'b0;
      frame_err <= 1'b0;
      overrun <= 1'b0;
    end else begin
      rx_s1 <= rxd;
      rx_s2 <= rx_s1;
      if (ce) rx_last <= rx_s2;
      rx_state <= rx_state_n;
      rx_cnt <= rx_cnt_n;
      rx_bit <= rx_bit_n;
      rx_sh <= rx_sh_n;
      // a byte landing alongside rd counts as fresh, not as an overrun
      if (rx_done) begin
        rx_data <= rx_sh;
        rx_full <= 1'b1;
        frame_err <= ~rx_s2;
        overrun <= ~rd & (overrun | rx_full);
      end else if (rd) begin
        rx_full <= 1'b0;
        overrun <= 1'b0;
      end
    end
endmodule
